// File: rtl/data_sram_responder.sv
// Responder end of the data_sram req/addr_ok/data_ok bus: in-order fixed-latency replies from a word memory.
// Optional RANDOM_STALL_EN adds LFSR-driven accept stalls to exercise initiator hold logic.
module data_sram_responder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addrok,
  output logic        data_sram_dataok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int LW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0]   LAT_INIT = LW'(LATENCY - 1);
  localparam logic [PW-1:0]   LAST     = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);

  logic [31:0]       mem [0:(2**ADDR_W)-1];
  logic [31:0]       q_data [DEPTH];
  logic [LW-1:0]     q_cnt [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [3:0]        wstrb;
  logic [31:0]       snapshot;
  logic              stall_ok;
  logic              accept;
  logic              pop;
  logic              unused_addr;

`ifdef RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end

  assign stall_ok = (lfsr[1:0] != 2'b00);
`else
  assign stall_ok = 1'b1;
`endif

  // Upper address bits alias onto the same word.
  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign lane        = data_sram_addr[1:0];
  assign unused_addr = ^data_sram_addr[31:ADDR_W+2];

  always_comb begin
    wstrb = 4'b0000;
    case (data_sram_size)
      2'd0:    wstrb = 4'b0001 << lane;
      2'd1:    wstrb = 4'b0011 << lane;
      default: wstrb = 4'b1111 << lane;
    endcase
  end

  // No pass-through: a full queue refuses even when the head pops this cycle.
  assign data_sram_addrok = data_sram_req && !reset && (count != FULL) && stall_ok;
  assign accept           = data_sram_addrok;
  assign pop              = (count != '0) && (q_cnt[rd_ptr] == '0);
  assign snapshot         = data_sram_wr ? 32'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Stale slots keep counting down harmlessly; a push always reloads its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
    end
    if (accept) begin
      q_data[wr_ptr] <= snapshot;
      q_cnt[wr_ptr]  <= LAT_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      data_sram_dataok <= 1'b0;
      data_sram_rdata  <= 32'h0;
    end else begin
      data_sram_dataok <= pop;
      if (pop) begin
        data_sram_rdata <= q_data[rd_ptr];
        rd_ptr          <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (accept) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
